// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between the UART receiver and the command engine.
// Absorbs received bytes and presents them first-word-fall-through with valid/ready.
// Optional build macro: UART_RX_FIFO_RTS_EN enables registered rts_n hysteresis.
// Ports:
//   clk, rst           clock; synchronous active-low reset (rst == 0)
//   rx_data, rx_strobe byte from the UART and its one-cycle strobe
//   out_data/valid     FIFO head byte; out_valid high while not empty
//   out_ready          consumer accepts the head byte
//   flush              discard all stored bytes
//   level              number of stored bytes, 0..2**ADDR_BITS
//   overflow, drop_cnt sticky drop flag and saturating dropped-byte count
//   clear_overflow     clears overflow and drop_cnt
//   rts_n              flow control to host, 0 = host may send
module uart_rx_fifo #(
  parameter int ADDR_BITS = 4,
  parameter int HIGH_MARK = 12,
  parameter int LOW_MARK  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_strobe,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [ADDR_BITS:0] level,
  output logic               overflow,
  input  logic               clear_overflow,
  output logic [7:0]         drop_cnt,
  output logic               rts_n
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] PTR_ONE  = (ADDR_BITS + 1)'(1);

  if (LOW_MARK >= HIGH_MARK) begin : g_bad_marks
    $error("uart_rx_fifo: LOW_MARK must be below HIGH_MARK");
  end

  logic [7:0]         mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign level     = wr_ptr - rd_ptr;
  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (level == FULL_LVL);
  assign out_data  = mem[rd_ptr[ADDR_BITS-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full
  // FIFO that is also being drained is accepted rather than dropped.
  assign pop  = out_valid && out_ready && !flush;
  assign push = rx_strobe && !flush && (!full || pop);
  assign drop = rx_strobe && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr[ADDR_BITS-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clear_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [ADDR_BITS:0] HI_LVL = (ADDR_BITS + 1)'(HIGH_MARK);
  localparam logic [ADDR_BITS:0] LO_LVL = (ADDR_BITS + 1)'(LOW_MARK);

  logic rts_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rts_q <= 1'b0;
    end else if (level >= HI_LVL) begin
      rts_q <= 1'b1;
    end else if (level <= LO_LVL) begin
      rts_q <= 1'b0;
    end
  end

  assign rts_n = rts_q;
`else
  assign rts_n = 1'b0;
`endif

endmodule
